// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI input test-pattern generator:
// pattern codes, the colour-bar table and RGB packing.
package hdmi_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_COLOURS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [31:0] pack_rgb(input logic [23:0] rgb);
    return {8'h00, rgb};
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical raster counters with sync and active-region decode.
// Decodes are combinational from the counter state; the parent registers them.
module video_timing_cnt #(
  parameter int H_RES  = 64,
  parameter int V_RES  = 64,
  parameter int H_FP   = 4,
  parameter int H_SYNC = 4,
  parameter int H_BP   = 4,
  parameter int V_FP   = 2,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 2,
  parameter int HW     = 7,
  parameter int VW     = 7
) (
  input  logic          hdmi_clk,
  input  logic          rst,
  input  logic          en,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          active,
  output logic          hs_n,
  output logic          vs_n,
  output logic          frame_start,
  output logic          frame_end
);

  localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_RES);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_RES + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_RES + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_RES);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_RES + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_RES + V_FP + V_SYNC);

  logic [HW-1:0] h_r;
  logic [VW-1:0] v_r;
  logic          h_last_s;
  logic          v_last_s;

  assign h_last_s = (h_r == H_LAST);
  assign v_last_s = (v_r == V_LAST);

  // Raster position; holds while en is low so a paused frame resumes in place.
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      h_r <= '0;
      v_r <= '0;
    end else if (en) begin
      if (h_last_s) begin
        h_r <= '0;
        v_r <= v_last_s ? '0 : v_r + VW'(1);
      end else begin
        h_r <= h_r + HW'(1);
      end
    end
  end

  assign h           = h_r;
  assign v           = v_r;
  assign active      = (h_r < H_ACT_END) && (v_r < V_ACT_END);
  assign hs_n        = !((h_r >= H_SYNC_BEG) && (h_r < H_SYNC_END));
  assign vs_n        = !((v_r >= V_SYNC_BEG) && (v_r < V_SYNC_END));
  assign frame_start = en && (h_r == '0) && (v_r == '0);
  assign frame_end   = en && h_last_s && v_last_s;

endmodule

// File: rtl/hdmi_in_gen.sv
// Test-pattern video source: raster timing plus frame-latched pattern
// selection, pixel generation and registered HDMI-style outputs.
module hdmi_in_gen
  import hdmi_pkg::*;
#(
  parameter int H_RES  = 64,
  parameter int V_RES  = 64,
  parameter int H_FP   = 4,
  parameter int H_SYNC = 4,
  parameter int H_BP   = 4,
  parameter int V_FP   = 2,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 2
) (
  input  logic        hdmi_clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        hdmi_vs,
  output logic        hdmi_hs,
  output logic        hdmi_de,
  output logic [31:0] hdmi_data,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  logic [HW-1:0] h_s;
  logic [VW-1:0] v_s;
  logic          active_s;
  logic          hs_n_s;
  logic          vs_n_s;
  logic          frame_start_s;
  logic          frame_end_s;

  video_timing_cnt #(
    .H_RES(H_RES), .V_RES(V_RES),
    .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .hdmi_clk    (hdmi_clk),
    .rst         (rst),
    .en          (en),
    .h           (h_s),
    .v           (v_s),
    .active      (active_s),
    .hs_n        (hs_n_s),
    .vs_n        (vs_n_s),
    .frame_start (frame_start_s),
    .frame_end   (frame_end_s)
  );

  pattern_e    pattern_r;
  logic [23:0] colour_r;
  logic [7:0]  frame_cnt_r;
  pattern_e    pat_s;
  logic [23:0] colour_s;
  logic [7:0]  h8_s;
  logic [7:0]  v8_s;
  logic [2:0]  bar_s;
  logic [23:0] pixel_rgb_s;
  logic        de_r;
  logic        hs_r;
  logic        vs_r;
  logic [31:0] data_r;

  // Pattern and colour are captured once per frame; the first pixel already uses the new choice.
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      pattern_r <= PAT_BARS;
      colour_r  <= 24'h000000;
    end else if (frame_start_s) begin
      pattern_r <= pattern_e'(pattern_sel);
      colour_r  <= solid_rgb;
    end
  end

  // Completed-frame counter, wraps naturally at 8 bits.
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      frame_cnt_r <= 8'd0;
    end else if (frame_end_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end
  end

  assign pat_s    = frame_start_s ? pattern_e'(pattern_sel) : pattern_r;
  assign colour_s = frame_start_s ? solid_rgb : colour_r;
  assign h8_s     = 8'(h_s);
  assign v8_s     = 8'(v_s);
  assign bar_s    = 3'((32'(h_s) * 32'd8) / 32'(H_RES));

  // Pixel colour for the current raster position.
  always_comb begin
    pixel_rgb_s = 24'h000000;
    case (pat_s)
      PAT_BARS:  pixel_rgb_s = BAR_COLOURS[bar_s];
      PAT_GRAD:  pixel_rgb_s = {h8_s, v8_s, frame_cnt_r};
      PAT_CHECK: pixel_rgb_s = (h8_s[3] ^ v8_s[3]) ? 24'h000000 : 24'hFFFFFF;
      PAT_SOLID: pixel_rgb_s = colour_s;
      default:   pixel_rgb_s = 24'h000000;
    endcase
  end

  // Output stage: one cycle behind the counters, idle while paused or in reset.
  always_ff @(posedge hdmi_clk) begin
    if (rst || !en) begin
      de_r   <= 1'b0;
      hs_r   <= 1'b1;
      vs_r   <= 1'b1;
      data_r <= 32'h0000_0000;
    end else begin
      de_r   <= active_s;
      hs_r   <= hs_n_s;
      vs_r   <= vs_n_s;
      data_r <= active_s ? pack_rgb(pixel_rgb_s) : 32'h0000_0000;
    end
  end

  assign hdmi_de   = de_r;
  assign hdmi_hs   = hs_r;
  assign hdmi_vs   = vs_r;
  assign hdmi_data = data_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_hdmi_in_gen.sv
// Directed bench for hdmi_in_gen: default-size instance for timing, patterns,
// pause and reset; a tiny-raster instance for the 256-frame gradient wrap.
module tb_hdmi_in_gen;

  logic        hdmi_clk = 1'b0;
  logic        rst, en, en2;
  logic [1:0]  pattern_sel, pat2;
  logic [23:0] solid_rgb;
  logic        hdmi_vs, hdmi_hs, hdmi_de;
  logic [31:0] hdmi_data;
  logic [7:0]  frame_cnt;
  logic        vs2, hs2, de2;
  logic [31:0] data2;
  logic [7:0]  fc2;

  always #5 hdmi_clk = ~hdmi_clk;

  hdmi_in_gen dut (
    .hdmi_clk(hdmi_clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .hdmi_vs(hdmi_vs), .hdmi_hs(hdmi_hs),
    .hdmi_de(hdmi_de), .hdmi_data(hdmi_data), .frame_cnt(frame_cnt)
  );

  // 8x2 active, H_TOT=11, V_TOT=5 -> 55 cycles per frame.
  hdmi_in_gen #(
    .H_RES(8), .V_RES(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut2 (
    .hdmi_clk(hdmi_clk), .rst(rst), .en(en2), .pattern_sel(pat2),
    .solid_rgb(solid_rgb), .hdmi_vs(vs2), .hdmi_hs(hs2),
    .hdmi_de(de2), .hdmi_data(data2), .frame_cnt(fc2)
  );

  int n_vec = 0;
  int n_miss = 0;
  int hm = 0, vm = 0, ph = 0, pv = 0;
  int de_cnt = 0, idle_bad = 0, tim_bad = 0;
  logic [31:0] pix [0:63][0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the default instance, checked against an independent raster model.
  task automatic step();
    logic e, exp_de, exp_hs, exp_vs;
    e = en;
    @(posedge hdmi_clk);
    #1;
    if (e) begin
      ph = hm; pv = vm;
      hm++;
      if (hm == 76) begin
        hm = 0; vm++;
        if (vm == 70) vm = 0;
      end
    end
    exp_de = e && (ph < 64) && (pv < 64);
    exp_hs = !(e && (ph >= 68) && (ph < 72));
    exp_vs = !(e && (pv >= 66) && (pv < 68));
    if (hdmi_de !== exp_de || hdmi_hs !== exp_hs || hdmi_vs !== exp_vs) tim_bad++;
    if (hdmi_de === 1'b1) begin
      de_cnt++;
      if (ph < 64 && pv < 64) pix[pv][ph] = hdmi_data;
    end else if (hdmi_data !== 32'h0) begin
      idle_bad++;
    end
  endtask

  task automatic run_to(input int h, input int v);
    int guard;
    guard = 0;
    while (!(hm == h && vm == v) && guard < 6000) begin
      step();
      guard++;
    end
    chk("run_to_bound", 32'(guard < 6000), 32'd1);
  endtask

  task automatic run_frame();
    repeat (5320) step();
  endtask

  initial begin
    int hs_first, vs_first, hs_low, vs_low, line0_de, bad, idle_cnt;
    int h2, v2, k, ph2, pv2, pk, g_bad, b_bad;
    logic saw255;
    logic [31:0] exp2;

    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    pattern_sel = 2'd0; pat2 = 2'd1; solid_rgb = 24'h000000;
    repeat (3) @(posedge hdmi_clk);
    #1;
    chk("rst_de", 32'(hdmi_de), 32'd0);
    chk("rst_hs", 32'(hdmi_hs), 32'd1);
    chk("rst_vs", 32'(hdmi_vs), 32'd1);
    chk("rst_data", hdmi_data, 32'h0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    @(posedge hdmi_clk);
    #1;
    chk("post_rst_de", 32'(hdmi_de), 32'd0);

    // Frame 0: colour bars, raw timing measurements.
    en = 1'b1;
    hs_first = -1; vs_first = -1; hs_low = 0; vs_low = 0; line0_de = 0; de_cnt = 0;
    for (int t = 0; t < 5320; t++) begin
      step();
      if (t == 0) chk("first_de", 32'(hdmi_de), 32'd1);
      if (!hdmi_hs) begin hs_low++; if (hs_first < 0) hs_first = t; end
      if (!hdmi_vs) begin vs_low++; if (vs_first < 0) vs_first = t; end
      if (t < 76 && hdmi_de) line0_de++;
    end
    chk("line_de", 32'(line0_de), 32'd64);
    chk("frame_de", 32'(de_cnt), 32'd4096);
    chk("hs_start", 32'(hs_first), 32'd68);
    chk("hs_low", 32'(hs_low), 32'd280);
    chk("vs_start", 32'(vs_first), 32'd5016);
    chk("vs_low", 32'(vs_low), 32'd152);
    chk("bar_px0", pix[0][0], 32'h00FFFFFF);
    chk("bar_px7", pix[0][7], 32'h00FFFFFF);
    chk("bar_px8", pix[0][8], 32'h00FFFF00);
    chk("bar_px15", pix[0][15], 32'h00FFFF00);
    chk("bar_px16", pix[0][16], 32'h0000FFFF);
    chk("bar_px56", pix[0][56], 32'h00000000);
    chk("bar_px63", pix[5][63], 32'h00000000);
    chk("fcnt_1", 32'(frame_cnt), 32'd1);

    // Frame 1: solid colour, pattern switched mid-frame must not tear.
    pattern_sel = 2'd3; solid_rgb = 24'h123456;
    run_to(0, 10);
    pattern_sel = 2'd2;
    run_to(0, 0);
    bad = 0;
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        if (pix[y][x] !== 32'h00123456) bad++;
    chk("solid_no_tear", 32'(bad), 32'd0);
    chk("solid_px", pix[40][33], 32'h00123456);

    // Frame 2: checker takes effect.
    run_frame();
    chk("chk_h8v0", pix[0][8], 32'h0);
    chk("chk_h0v0", pix[0][0], 32'h00FFFFFF);
    chk("chk_h0v8", pix[8][0], 32'h0);
    chk("chk_h8v8", pix[8][8], 32'h00FFFFFF);
    chk("chk_h63v63", pix[63][63], 32'h00FFFFFF);
    chk("fcnt_3", 32'(frame_cnt), 32'd3);

    // Frame 3: bars with a 100-cycle pause in line 5.
    pattern_sel = 2'd0; de_cnt = 0;
    run_to(30, 5);
    en = 1'b0;
    idle_cnt = 0;
    repeat (100) begin
      step();
      if (hdmi_de || !hdmi_hs || !hdmi_vs || hdmi_data != 32'h0) idle_cnt++;
    end
    chk("pause_idle", 32'(idle_cnt), 32'd0);
    chk("pause_fcnt", 32'(frame_cnt), 32'd3);
    en = 1'b1;
    step();
    chk("resume_de", 32'(hdmi_de), 32'd1);
    chk("resume_px30", hdmi_data, 32'h0000FF00);
    run_to(0, 0);
    chk("pause_frame_de", 32'(de_cnt), 32'd4096);
    chk("fcnt_4", 32'(frame_cnt), 32'd4);

    // Mid-frame reset restarts at the origin.
    run_to(20, 3);
    rst = 1'b1;
    repeat (2) @(posedge hdmi_clk);
    #1;
    chk("midrst_de", 32'(hdmi_de), 32'd0);
    chk("midrst_data", hdmi_data, 32'h0);
    chk("midrst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0; hm = 0; vm = 0; de_cnt = 0;
    step();
    chk("midrst_px0", hdmi_data, 32'h00FFFFFF);
    run_to(0, 0);
    chk("midrst_frame_de", 32'(de_cnt), 32'd4096);
    chk("fcnt_after_rst", 32'(frame_cnt), 32'd1);
    chk("timing_errs", 32'(tim_bad), 32'd0);
    chk("idle_data_errs", 32'(idle_bad), 32'd0);

    // Small instance: 256 gradient frames and the frame counter wrap.
    en = 1'b0;
    en2 = 1'b1;
    h2 = 0; v2 = 0; k = 0; g_bad = 0; b_bad = 0; saw255 = 1'b0;
    repeat (256 * 55) begin
      @(posedge hdmi_clk);
      #1;
      ph2 = h2; pv2 = v2; pk = k;
      h2++;
      if (h2 == 11) begin
        h2 = 0; v2++;
        if (v2 == 5) begin v2 = 0; k = (k + 1) % 256; end
      end
      if (ph2 < 8 && pv2 < 2) begin
        exp2 = {8'h00, 8'(ph2), 8'(pv2), 8'(pk)};
        if (de2 !== 1'b1 || data2 !== exp2) g_bad++;
        if (data2[7:0] !== fc2) b_bad++;
      end else if (de2 !== 1'b0 || data2 !== 32'h0) begin
        g_bad++;
      end
      if (hs2 !== !(ph2 == 9) || vs2 !== !(pv2 == 3)) g_bad++;
      if (fc2 !== 8'(k)) g_bad++;
      if (fc2 == 8'd255) saw255 = 1'b1;
    end
    chk("grad_errs", 32'(g_bad), 32'd0);
    chk("grad_b_eq_fcnt", 32'(b_bad), 32'd0);
    chk("fcnt_saw_255", 32'(saw255), 32'd1);
    chk("fcnt_wrapped", 32'(fc2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
